// File: rtl/fifo_axis_pkg.sv
// rtl/fifo_axis_pkg.sv - shared types and sizing helpers for the FIFO read-side drain engine
package fifo_axis_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IN_PKT  = 2'd1,
        DISCARD = 2'd2
    } rd_state_e;

    localparam int DEF_PKT_CNT_W = 16;

    function automatic int beat_cnt_w(input int max_pkt_len);
        return (max_pkt_len > 1) ? $clog2(max_pkt_len) : 1;
    endfunction

endpackage

// File: rtl/fifo_axis_obuf.sv
// rtl/fifo_axis_obuf.sv - 2-entry {data, last} output buffer with head registered straight to the stream
module fifo_axis_obuf #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  m_clk,
    input  logic                  m_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_last,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic                  head_last,
    output logic [1:0]            occ
);

    logic [DATA_WIDTH-1:0] tail_data;
    logic                  tail_last;

    // Head is always the oldest entry, so the stream outputs never pass through a mux.
    always_ff @(posedge m_clk or posedge m_rst) begin
        if (m_rst) begin
            head_data <= '0;
            head_last <= 1'b0;
            tail_data <= '0;
            tail_last <= 1'b0;
            occ       <= 2'd0;
        end else begin
            case ({wr_en, pop})
                2'b10: begin
                    if (occ == 2'd0) begin
                        head_data <= wr_data;
                        head_last <= wr_last;
                    end else begin
                        tail_data <= wr_data;
                        tail_last <= wr_last;
                    end
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head_data <= tail_data;
                    head_last <= tail_last;
                    occ       <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head_data <= wr_data;
                        head_last <= wr_last;
                    end else begin
                        head_data <= tail_data;
                        head_last <= tail_last;
                        tail_data <= wr_data;
                        tail_last <= wr_last;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fifo_axis_reader.sv
// rtl/fifo_axis_reader.sv - drains the async FIFO into an AXI-Stream master with packet-length truncation
module fifo_axis_reader
    import fifo_axis_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MAX_PKT_LEN = 16,
    parameter int PKT_CNT_W   = DEF_PKT_CNT_W
) (
    input  logic                  m_clk,
    input  logic                  m_rst,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_tdata,
    input  logic                  fifo_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic [PKT_CNT_W-1:0]  pkt_count,
    output logic                  trunc_err,
    output logic                  busy
);

    localparam int               CNT_W    = beat_cnt_w(MAX_PKT_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT_LEN - 1);

    rd_state_e        state;
    logic             inflight;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       occ;
    logic [2:0]       level;
    logic             pop;
    logic             wr_en;
    logic             wr_last;
    logic             at_limit;

    assign pop      = m_axis_tvalid && m_axis_tready;
    // Count the word still on its way back so the buffer can never be over-committed.
    assign level    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = !m_rst && !fifo_empty && (level < 3'd2);

    assign at_limit = (beat_cnt == CNT_LAST);
    assign wr_en    = inflight && (state != DISCARD);
    assign wr_last  = fifo_tlast || at_limit;

    assign m_axis_tvalid = (occ != 2'd0);
    assign busy          = (state != IDLE) || inflight || (occ != 2'd0);

    fifo_axis_obuf #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_obuf (
        .m_clk     (m_clk),
        .m_rst     (m_rst),
        .wr_en     (wr_en),
        .wr_data   (fifo_tdata),
        .wr_last   (wr_last),
        .pop       (pop),
        .head_data (m_axis_tdata),
        .head_last (m_axis_tlast),
        .occ       (occ)
    );

    always_ff @(posedge m_clk or posedge m_rst) begin
        if (m_rst) begin
            state     <= IDLE;
            inflight  <= 1'b0;
            beat_cnt  <= '0;
            pkt_count <= '0;
            trunc_err <= 1'b0;
        end else begin
            inflight  <= fifo_rd_en;
            trunc_err <= 1'b0;
            if (pop && m_axis_tlast) begin
                pkt_count <= pkt_count + 1'b1;
            end
            if (inflight) begin
                if (state == DISCARD) begin
                    if (fifo_tlast) begin
                        state <= IDLE;
                    end
                end else if (fifo_tlast) begin
                    beat_cnt <= '0;
                    state    <= IDLE;
                end else if (at_limit) begin
                    beat_cnt  <= '0;
                    trunc_err <= 1'b1;
                    state     <= DISCARD;
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    state    <= IN_PKT;
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_axis_reader.sv
// tb/tb_fifo_axis_reader.sv - scoreboard bench driving two reader configurations from one packet stream
module tb_fifo_axis_reader;

    localparam int DW    = 8;
    localparam int DEPTH = 512;
    localparam int MAXL0 = 16;
    localparam int MAXL1 = 4;
    localparam int CW0   = 16;
    localparam int CW1   = 2;

    logic m_clk = 1'b0;
    logic m_rst = 1'b1;
    logic m_axis_tready = 1'b0;
    int   rdy_mode = 1;

    always #5 m_clk = ~m_clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [8:0]    fmem   [2][DEPTH];
    int            wp     [2];
    logic [DW-1:0] e_data [2][DEPTH];
    logic          e_last [2][DEPTH];
    int            e_pc   [2][DEPTH];
    int            ew     [2];
    int            pk     [2];
    int            exp_trunc [2];
    logic [DW-1:0] pw     [32];

    int            er_w   [2];
    int            hs_w   [2];
    int            rd_w   [2];
    int            tr_w   [2];
    int            viol_w [2];
    int            pc_w   [2];
    logic          busy_w [2];
    logic          tvalid_w [2];
    logic          tlast_w  [2];
    logic          trunc_w  [2];
    logic          rden_w   [2];
    logic          empty_w  [2];
    logic [DW-1:0] tdata_w  [2];

    task automatic chk(input string name, input int lane, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s lane%0d: got %0h expected %0h", name, lane, act, exp);
    endtask

    always begin
        @(posedge m_clk);
        #1;
        case (rdy_mode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = 1'($urandom_range(0, 1));
        endcase
    end

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int MAXL = (g == 0) ? MAXL0 : MAXL1;
        localparam int CW   = (g == 0) ? CW0 : CW1;

        logic          fifo_empty;
        logic          fifo_rd_en;
        logic [DW-1:0] fifo_tdata = '0;
        logic          fifo_tlast = 1'b0;
        logic [DW-1:0] tdata;
        logic          tlast;
        logic          tvalid;
        logic [CW-1:0] pkt_count;
        logic          trunc_err;
        logic          busy;

        int            rp = 0;
        int            er = 0;
        int            hs = 0;
        int            rd = 0;
        int            tr = 0;
        int            viol = 0;
        logic          stall = 1'b0;
        logic [DW-1:0] held_d = '0;
        logic          held_l = 1'b0;
        logic          pc_chk = 1'b0;
        int            pc_exp = 0;

        fifo_axis_reader #(
            .DATA_WIDTH  (DW),
            .MAX_PKT_LEN (MAXL),
            .PKT_CNT_W   (CW)
        ) dut (
            .m_clk         (m_clk),
            .m_rst         (m_rst),
            .fifo_empty    (fifo_empty),
            .fifo_rd_en    (fifo_rd_en),
            .fifo_tdata    (fifo_tdata),
            .fifo_tlast    (fifo_tlast),
            .m_axis_tdata  (tdata),
            .m_axis_tlast  (tlast),
            .m_axis_tvalid (tvalid),
            .m_axis_tready (m_axis_tready),
            .pkt_count     (pkt_count),
            .trunc_err     (trunc_err),
            .busy          (busy)
        );

        assign fifo_empty  = (rp == wp[g]);
        assign er_w[g]     = er;
        assign hs_w[g]     = hs;
        assign rd_w[g]     = rd;
        assign tr_w[g]     = tr;
        assign viol_w[g]   = viol;
        assign pc_w[g]     = int'(pkt_count);
        assign busy_w[g]   = busy;
        assign tvalid_w[g] = tvalid;
        assign tlast_w[g]  = tlast;
        assign trunc_w[g]  = trunc_err;
        assign rden_w[g]   = fifo_rd_en;
        assign empty_w[g]  = fifo_empty;
        assign tdata_w[g]  = tdata;

        // FIFO read port: one-cycle read latency, flushed while the reader is in reset.
        always @(posedge m_clk) begin
            if (m_rst) begin
                rp <= wp[g];
            end else if (fifo_rd_en) begin
                {fifo_tlast, fifo_tdata} <= fmem[g][rp % DEPTH];
                rp <= rp + 1;
                rd <= rd + 1;
            end
        end

        always begin
            @(negedge m_clk);
            if (m_rst) begin
                er     = ew[g];
                stall  = 1'b0;
                pc_chk = 1'b0;
            end else begin
                if (fifo_rd_en && fifo_empty) viol = viol + 1;
                if (trunc_err) tr = tr + 1;
                if (pc_chk) begin
                    chk("pkt_count", g, longint'(pkt_count), longint'(pc_exp));
                    pc_chk = 1'b0;
                end
                if (stall) begin
                    chk("hold_valid", g, longint'(tvalid), 1);
                    chk("hold_data", g, longint'({tlast, tdata}), longint'({held_l, held_d}));
                    stall = 1'b0;
                end
                if (tvalid && m_axis_tready) begin
                    hs = hs + 1;
                    chk("beat_expected", g, longint'(er < ew[g]), 1);
                    if (er < ew[g]) begin
                        chk("tdata", g, longint'(tdata), longint'(e_data[g][er % DEPTH]));
                        chk("tlast", g, longint'(tlast), longint'(e_last[g][er % DEPTH]));
                        pc_exp = e_pc[g][er % DEPTH];
                        pc_chk = 1'b1;
                        er     = er + 1;
                    end
                end else if (tvalid) begin
                    stall  = 1'b1;
                    held_d = tdata;
                    held_l = tlast;
                end
            end
        end
    end

    // Packet-level reference: keep the first MAX beats, force last on the final kept beat.
    task automatic push_pkt(input int len);
        for (int l = 0; l < 2; l++) begin
            int maxl = (l == 0) ? MAXL0 : MAXL1;
            int cw   = (l == 0) ? CW0 : CW1;
            int keep = (len < maxl) ? len : maxl;
            for (int i = 0; i < keep; i++) begin
                e_data[l][ew[l] % DEPTH] = pw[i];
                e_last[l][ew[l] % DEPTH] = (i == keep - 1);
                if (i == keep - 1) pk[l] = (pk[l] + 1) % (1 << cw);
                e_pc[l][ew[l] % DEPTH] = pk[l];
                ew[l]++;
            end
            if (len > maxl) exp_trunc[l]++;
            for (int i = 0; i < len; i++) begin
                fmem[l][wp[l] % DEPTH] = {1'(i == len - 1), pw[i]};
                wp[l]++;
            end
        end
    endtask

    task automatic drain(input int budget);
        int  cyc = 0;
        logic done = 1'b0;
        while (cyc < budget && !done) begin
            @(posedge m_clk);
            cyc++;
            done = (er_w[0] == ew[0]) && (er_w[1] == ew[1]) && empty_w[0] && empty_w[1]
                   && !busy_w[0] && !busy_w[1];
        end
        for (int l = 0; l < 2; l++) chk("drain_done", l, longint'(done), 1);
    endtask

    task automatic phase_checks();
        for (int l = 0; l < 2; l++) begin
            chk("pkt_count_end", l, longint'(pc_w[l]), longint'(pk[l]));
            chk("trunc_pulses", l, longint'(tr_w[l]), longint'(exp_trunc[l]));
        end
    endtask

    task automatic check_reset();
        for (int l = 0; l < 2; l++) begin
            chk("rst_rd_en", l, longint'(rden_w[l]), 0);
            chk("rst_tvalid", l, longint'(tvalid_w[l]), 0);
            chk("rst_tdata", l, longint'(tdata_w[l]), 0);
            chk("rst_tlast", l, longint'(tlast_w[l]), 0);
            chk("rst_pkt_count", l, longint'(pc_w[l]), 0);
            chk("rst_trunc_err", l, longint'(trunc_w[l]), 0);
            chk("rst_busy", l, longint'(busy_w[l]), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int rd0 [2];
        int hs0 [2];
        int total;
        int len;

        for (int l = 0; l < 2; l++) begin
            wp[l] = 0; ew[l] = 0; pk[l] = 0; exp_trunc[l] = 0;
        end

        repeat (3) @(posedge m_clk);
        @(negedge m_clk);
        check_reset();
        m_rst = 1'b0;

        // Single 16-word packet.
        for (int i = 0; i < 16; i++) pw[i] = 8'(i);
        push_pkt(16);
        drain(300);
        phase_checks();

        // Backpressure: five words arrive while the sink is stalled.
        @(negedge m_clk);
        rdy_mode = 0;
        @(posedge m_clk);
        @(posedge m_clk);
        #2;
        for (int l = 0; l < 2; l++) rd0[l] = rd_w[l];
        pw[0] = 8'h30; pw[1] = 8'h31; pw[2] = 8'h32;
        push_pkt(3);
        pw[0] = 8'h33; pw[1] = 8'h34;
        push_pkt(2);
        repeat (10) @(posedge m_clk);
        #2;
        for (int l = 0; l < 2; l++) chk("stall_rd_pulses", l, longint'(rd_w[l] - rd0[l]), 2);
        @(negedge m_clk);
        rdy_mode = 1;
        @(posedge m_clk);
        for (int l = 0; l < 2; l++) hs0[l] = hs_w[l];
        repeat (5) @(posedge m_clk);
        for (int l = 0; l < 2; l++) chk("release_rate", l, longint'(hs_w[l] - hs0[l]), 5);
        drain(300);
        phase_checks();

        // Over-long packet followed by a short one.
        for (int i = 0; i < 6; i++) pw[i] = 8'hA0 + 8'(i);
        push_pkt(6);
        pw[0] = 8'hB0; pw[1] = 8'hB1;
        push_pkt(2);
        drain(300);
        phase_checks();

        // Random packets, random sink readiness.
        @(negedge m_clk);
        rdy_mode = 2;
        total = 0;
        while (total < 200) begin
            len = $urandom_range(1, 16);
            if (len > 200 - total) len = 200 - total;
            for (int i = 0; i < len; i++) pw[i] = 8'($urandom_range(0, 255));
            push_pkt(len);
            total += len;
        end
        drain(3000);
        phase_checks();

        // Reset while both buffer entries are occupied.
        @(negedge m_clk);
        rdy_mode = 0;
        @(posedge m_clk);
        @(posedge m_clk);
        #2;
        pw[0] = 8'h50; pw[1] = 8'h51; pw[2] = 8'h52;
        push_pkt(3);
        repeat (6) @(posedge m_clk);
        @(negedge m_clk);
        #2;
        for (int l = 0; l < 2; l++) begin
            chk("pre_rst_tvalid", l, longint'(tvalid_w[l]), 1);
            chk("pre_rst_fifo_left", l, longint'(empty_w[l]), 0);
        end
        m_rst = 1'b1;
        #1;
        check_reset();
        for (int l = 0; l < 2; l++) pk[l] = 0;
        repeat (3) @(posedge m_clk);
        @(negedge m_clk);
        m_rst = 1'b0;
        rdy_mode = 1;

        // One-word packets after reset exercise the counter wrap on the narrow lane.
        for (int i = 0; i < 5; i++) begin
            pw[0] = 8'hC0 + 8'(i);
            push_pkt(1);
        end
        for (int i = 0; i < 3; i++) pw[i] = 8'hD0 + 8'(i);
        push_pkt(3);
        drain(300);
        phase_checks();

        for (int l = 0; l < 2; l++) chk("rd_while_empty", l, longint'(viol_w[l]), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fifo_axis_reader.md
# fifo_axis_reader

Read-side drain engine for the async FIFO. It pops words from the FIFO read port (`rd_en`/`empty`, data plus last flag, one-cycle read latency) and presents them as an AXI-Stream master. Full-rate, bubble-free streaming is provided by a 2-entry output buffer. The block enforces a maximum packet length: over-long packets are truncated, and the remainder of the packet is discarded. It sits in the `m_clk` domain between the FIFO and downstream stream consumers.

## Interface
- `DATA_WIDTH`, 8, data word width; must match the FIFO.
- `MAX_PKT_LEN`, 16, maximum beats per packet (≥2).
- `PKT_CNT_W`, 16, width of the packet counter.
- `m_clk`  in  1  clock; read-side clock domain.
- `m_rst`  in  1  reset; asynchronous, active-high.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_rd_en`  out  1  FIFO pop request.
- `fifo_tdata`  in  DATA_WIDTH  FIFO read data, valid the cycle after `fifo_rd_en`.
- `fifo_tlast`  in  1  FIFO last flag, same timing as `fifo_tdata`.
- `m_axis_tdata`  out  DATA_WIDTH  stream data.
- `m_axis_tlast`  out  1  stream end of packet.
- `m_axis_tvalid`  out  1  stream valid.
- `m_axis_tready`  in  1  stream ready.
- `pkt_count`  out  PKT_CNT_W  completed packets handed off downstream.
- `trunc_err`  out  1  one-cycle pulse when a packet is truncated.
- `busy`  out  1  high when state ≠ IDLE, or a read is in flight, or the buffer is non-empty.

## Operation
- Reset values:
  - `fifo_rd_en`=0, `m_axis_tvalid`=0, `m_axis_tdata`=0, `m_axis_tlast`=0.
  - `pkt_count`=0, `trunc_err`=0, `busy`=0.
  - state=IDLE; buffer empty; in-flight flag=0; beat counter=0.
- Pop rule: `fifo_rd_en` = `!fifo_empty` && (occ + inflight − pop) < 2.
  - occ = buffer entries (0..2).
  - inflight = a read was issued last cycle.
  - pop = `m_axis_tvalid && m_axis_tready`.
- Returned word handling: in the cycle after a read is issued, the returned word is processed according to the current state.
- State machine. It advances on returned words only, never on AXI handshakes.
  - IDLE/IN_PKT:
    - The word is written to the buffer and the beat counter increments.
    - If `fifo_tlast`=1: counter←0, next state IDLE.
    - Else if the counter equals `MAX_PKT_LEN`−1:
      - the buffered tlast is forced to 1;
      - `trunc_err` pulses;
      - counter←0;
      - next state DISCARD.
    - Otherwise: next state IN_PKT.
  - DISCARD:
    - The word is dropped; it is not written to the buffer.
    - On `fifo_tlast`=1 → IDLE.
- AXI output:
  - `m_axis_tvalid` = occ>0.
  - Data and last come from the buffer head.
  - Data and last are held stable while `tvalid && !tready`.
- `pkt_count` increments on each handshake with `m_axis_tlast`=1, including truncated packets. It wraps modulo 2^PKT_CNT_W.
- Simultaneous buffer write and pop in the same cycle is legal, and occ is unchanged.
- Reset mid-operation:
  - Buffer contents and any in-flight word are lost.
  - The FIFO word already popped is not recovered.

## Timing
- Latency:
  - `fifo_rd_en` high at cycle N → word captured at the end of N+1 → `m_axis_tvalid` high in N+2.
  - The FIFO going non-empty leads to the first `tvalid` 2 cycles later.
- Throughput: 1 beat/cycle sustained while the FIFO stays non-empty and `tready`=1.
- Backpressure:
  - With `tready`=0, at most 2 further words are popped.
  - After that, `fifo_rd_en` stays 0 until a pop.
  - The buffer never overflows.
- `trunc_err` is asserted in the cycle after the capture edge of the offending word, for 1 cycle.
- All outputs are registered except `fifo_rd_en`, which is combinational from registered state, `fifo_empty` and `m_axis_tready`.

## Structure
- Package `fifo_axis_pkg` holds:
  - the state enum `rd_state_e` {IDLE, IN_PKT, DISCARD};
  - the default `PKT_CNT_W`;
  - the beat-counter width function, $clog2(MAX_PKT_LEN).
- Sub-module `fifo_axis_obuf`: a 2-entry buffer holding {data, last}, with write/pop ports and an occupancy output.
- The top level holds the pop-rule logic, the in-flight flag, the FSM, the beat counter and the packet counter.

## Test plan
- Single packet: write 0x00..0x0F with last on 0x0F; `tready`=1.
  - Required: 16 beats 0x00..0x0F with `tlast` only on 0x0F.
  - Required: `pkt_count`=1 and `trunc_err` never asserted.
- Backpressure: hold `tready`=0 for 10 cycles while the FIFO holds 5 words.
  - Required: exactly 2 `fifo_rd_en` pulses during the stall.
  - Required: data stable through the stall.
  - Required: after release, all 5 words are delivered in order at 1 beat/cycle.
- Truncation with `MAX_PKT_LEN`=4: send a 6-word packet 0xA0..0xA5 (last on 0xA5), then a 2-word packet 0xB0..0xB1.
  - Required output: 0xA0..0xA3, with `tlast` on 0xA3.
  - Required: one `trunc_err` pulse, and 0xA4..0xA5 dropped.
  - Required: 0xB0, 0xB1 delivered with `tlast` on 0xB1; `pkt_count`=2.
- Random `tready` (50%) over 200 words in packets of random length ≤ `MAX_PKT_LEN`.
  - Required: output sequence equals input sequence.
  - Required: no duplicates or losses; no `fifo_rd_en` while `fifo_empty`.
- Reset mid-packet:
  - Stimulus: assert `m_rst` while occ=2.
  - Required: all outputs return to reset values immediately.
  - Required: after release, the next packet streams correctly from IDLE.
- Packet-counter wrap with `PKT_CNT_W`=2: send 5 one-word packets.
  - Required: `pkt_count` sequence 1, 2, 3, 0, 1.
